// File: rtl/dmem_ctrl.sv
// dmem_ctrl: round-robin arbiter and byte sequencer in front of a byte-wide
// single-port data memory. Two requesters issue byte or word loads/stores;
// a word is split into four little-endian byte accesses.
//
// Latency (grant at edge E): store done at E+N+1, load done at E+N+2,
// range error done at E+1 (N = 1 byte / 4 word).
// Backpressure: one access at a time; req_ready only pulses in IDLE, so a
// requester holds its request until it sees its ready bit.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/write/word [1:0] per-port request qualifiers (bit i = port i)
//   req{0,1}_addr/_wdata       per-port byte address and store data
//   req_ready [1:0]            one-hot accept strobe (combinational, IDLE only)
//   done [1:0]                 one-cycle completion pulse to owning port
//   rdata, err                 load result / range error, valid with done
//   busy                       high whenever not IDLE
//   mem_addr/re/we/wdata       byte strobes to memory
//   mem_rdata                  memory read data, one cycle after mem_re
module dmem_ctrl #(
  parameter int unsigned MEM_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [1:0]  req_word,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req0_wdata,
  input  logic [31:0] req1_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Controller state
  state_e      state_q;
  logic [1:0]  k_q;
  logic        last_q;
  logic        port_q;
  logic        write_q;
  logic        word_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] result_q;

  // Registered outputs
  logic [1:0]  done_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        busy_q;
  logic [31:0] mem_addr_q;
  logic        mem_re_q;
  logic        mem_we_q;
  logic [7:0]  mem_wdata_q;

  // Grant-cycle decode
  logic        gnt_vld;
  logic        gnt_port_d;
  logic [31:0] gnt_addr;
  logic [31:0] gnt_wdata;
  logic        gnt_write;
  logic        gnt_word;
  logic [32:0] gnt_end;
  logic        range_err;

  // Access-phase helpers
  logic [1:0]  last_k;
  logic [1:0]  k_nxt;
  logic [1:0]  cap_idx;
  logic [31:0] result_d;
  logic [1:0]  port_oh;

  // Round-robin: on a tie serve the port that was not served last.
  always_comb begin
    gnt_port_d = 1'b0;
    if (req_valid == 2'b11) begin
      gnt_port_d = ~last_q;
    end else if (req_valid[1]) begin
      gnt_port_d = 1'b1;
    end
  end

  assign gnt_vld   = |req_valid;
  assign gnt_addr  = gnt_port_d ? req1_addr  : req0_addr;
  assign gnt_wdata = gnt_port_d ? req1_wdata : req0_wdata;
  assign gnt_write = req_write[gnt_port_d];
  assign gnt_word  = req_word[gnt_port_d];

  // Last byte address computed in 33 bits so addresses near 2^32 cannot wrap
  // back into the legal range.
  assign gnt_end   = {1'b0, gnt_addr} + (gnt_word ? 33'd3 : 33'd0);
  assign range_err = (gnt_end >= 33'(MEM_BYTES));

  // Ready is gated with rst_n so no accept strobe is shown while in reset.
  always_comb begin
    req_ready = 2'b00;
    if (rst_n && (state_q == IDLE) && gnt_vld) begin
      req_ready[gnt_port_d] = 1'b1;
    end
  end

  assign last_k  = word_q ? 2'd3 : 2'd0;
  assign k_nxt   = k_q + 2'd1;
  assign port_oh = port_q ? 2'b10 : 2'b01;

  // Read data lags the strobe by one cycle: during ACCESS byte k we receive
  // byte k-1; in FLUSH we receive the final byte (k still holds N-1).
  assign cap_idx = (state_q == FLUSH) ? k_q : (k_q - 2'd1);

  always_comb begin
    result_d = result_q;
    result_d[{cap_idx, 3'b000} +: 8] = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= 2'd0;
      last_q      <= 1'b1;
      port_q      <= 1'b0;
      write_q     <= 1'b0;
      word_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      result_q    <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      // Pulse-style outputs default low; states below raise them as needed.
      done_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;

      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            last_q   <= gnt_port_d;
            port_q   <= gnt_port_d;
            write_q  <= gnt_write;
            word_q   <= gnt_word;
            addr_q   <= gnt_addr;
            wdata_q  <= gnt_wdata;
            result_q <= '0;
            k_q      <= 2'd0;
            busy_q   <= 1'b1;
            if (range_err) begin
              state_q <= DONE;
              done_q  <= gnt_port_d ? 2'b10 : 2'b01;
              err_q   <= 1'b1;
            end else begin
              // First byte strobe is presented in the first ACCESS cycle.
              state_q    <= ACCESS;
              mem_addr_q <= gnt_addr;
              if (gnt_write) begin
                mem_we_q    <= 1'b1;
                mem_wdata_q <= gnt_wdata[7:0];
              end else begin
                mem_re_q <= 1'b1;
              end
            end
          end
        end

        ACCESS: begin
          if (!write_q && (k_q != 2'd0)) begin
            result_q <= result_d;
          end
          if (k_q == last_k) begin
            if (write_q) begin
              state_q <= DONE;
              done_q  <= port_oh;
            end else begin
              state_q <= FLUSH;
            end
          end else begin
            k_q        <= k_nxt;
            mem_addr_q <= addr_q + {30'd0, k_nxt};
            if (write_q) begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= wdata_q[{k_nxt, 3'b000} +: 8];
            end else begin
              mem_re_q <= 1'b1;
            end
          end
        end

        FLUSH: begin
          result_q <= result_d;
          rdata_q  <= result_d;
          done_q   <= port_oh;
          state_q  <= DONE;
        end

        DONE: begin
          busy_q  <= 1'b0;
          k_q     <= 2'd0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign done      = done_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Sequencer and arbiter in front of the byte-wide, single-port data memory. Two requesters (port 0: pipeline load/store stage; port 1: debug/DMA loader) issue byte (LDB/STB) or word (LDW/STW) accesses. The controller grants one request at a time by round-robin, breaks word accesses into four sequential little-endian byte accesses, and returns read data with a completion pulse and a range-error flag.

## Interface

Parameters:
- MEM_BYTES, 16, number of addressable bytes; legal addresses 0..MEM_BYTES-1

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-port request valid; bit i = port i
- req_write  in  2  per-port 1=store, 0=load
- req_word  in  2  per-port 1=word (4 bytes), 0=byte
- req0_addr, req1_addr  in  32  byte address
- req0_wdata, req1_wdata  in  32  store data; byte uses [7:0]
- req_ready  out  2  one-hot accept strobe; request captured on that edge
- done  out  2  one-cycle completion pulse, one-hot to owning port
- rdata  out  32  load result, valid only while done!=0
- err  out  1  range error, valid only while done!=0
- busy  out  1  high in any state except IDLE
- mem_addr  out  32  byte address to memory
- mem_re  out  1  byte read strobe
- mem_we  out  1  byte write strobe
- mem_wdata  out  8  byte write data
- mem_rdata  in  8  read data; synchronous, valid the cycle after mem_re

## Operation

- States: IDLE, ACCESS, FLUSH, DONE.
- IDLE: if any req_valid, grant one port; req_ready[g]=1 combinationally in that cycle; latch addr, wdata, write, word, port at the edge; next state ACCESS, or DONE if range error.
- Arbitration: round-robin on last-served pointer `last`. Both valid -> grant port != last; one valid -> grant it. After reset `last`=1, so port 0 wins first tie. `last` updates at grant.
- Range check at grant, 33-bit arithmetic: error if addr + N - 1 >= MEM_BYTES, N = 4 (word) or 1 (byte). Includes addr near 2^32 with no wrap. On error: no mem_re/mem_we, go to DONE with err=1, rdata=0.
- ACCESS: byte counter k = 0..N-1, one byte per cycle; mem_addr = addr + k.
  - Store: mem_we=1, mem_wdata = wdata[8k+7:8k]. After k=N-1 -> DONE.
  - Load: mem_re=1; mem_rdata arriving in cycle k+1 is captured into result byte k. After k=N-1 -> FLUSH.
- FLUSH (loads only): capture last byte, no strobes; -> DONE.
- DONE: done[port]=1 for one cycle; rdata = assembled word (byte load zero-extended; store -> 0); err as computed; -> IDLE. No grant in DONE.
- Unaligned word addresses are legal.
- Requesters hold valid/addr/wdata/write/word stable until req_ready; they may drop valid after ready. valid dropped before ready: no access.
- mem_addr, mem_wdata = 0 and mem_re = mem_we = 0 outside ACCESS.

## Timing

- Reset (async assert, sync release): state IDLE, k=0, `last`=1, all outputs 0 (req_ready, done, rdata, err, busy, mem_*). In-flight operation abandoned; bytes already written stay written, no done issued.
- Grant at edge E (req_ready high in the cycle before E). ACCESS occupies cycles E+1..E+N.
- Store: done in cycle E+N+1 (byte: E+2; word: E+5).
- Load: FLUSH E+N+1, done E+N+2 (byte: E+3; word: E+6).
- Error: done in cycle E+1.
- Back-to-back: earliest next grant in the IDLE cycle after DONE, i.e. edge following it; minimum spacing between grants = store N+2, load N+3, error 2 cycles.
- Request arriving in the same cycle done is raised is not accepted until the following IDLE cycle.

## Test plan

- Word store then load, port 0, addr 4, wdata 0xA1B2C3D4 -> mem_we at addrs 4,5,6,7 with D4,C3,B2,A1; done[0] at E+5; load returns rdata=0xA1B2C3D4 with done[0] at E+6, err=0.
- Byte load port 1, addr 3, memory byte 0x9F -> single mem_re at 3, rdata=0x0000009F, done[1] at E+3.
- Both ports valid continuously from reset -> grants alternate 0,1,0,1; each port done exactly once per two transactions; no starvation over 10 requests.
- Range: MEM_BYTES=16, word load at addr 13, and word at 0xFFFFFFFE -> no mem strobes, done at E+1, err=1, rdata=0; word at 12 -> err=0.
- Reset asserted during ACCESS of word store at k=2 -> all outputs 0 immediately, bytes 0-1 written, bytes 2-3 unchanged, no done; next request after release granted to port 0 on tie.
- Request with valid dropped before grant while other port busy -> no access, no done for that port.
